video_drive_sequencer: RTL



---
 rtl/video_drive_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/video_drive_sequencer.sv
// Frame-synchronous drive sequencer: combines the panel drive level with a drum-triggered envelope.
module video_drive_sequencer #(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned ATTACK_STEP = 128,
  parameter int unsigned DECAY_STEP  = 16,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_count_in,
  input  logic [9:0]  v_count_in,
  input  logic [9:0]  knob_drive,
  input  logic        trig,
  input  logic [6:0]  trig_velocity,
  output logic [9:0]  drive_out,
  output logic [9:0]  env_level,
  output logic        busy,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    HOLD,
    DECAY
  } state_e;

`ifdef VIDEO_DRIVE_KNOB_SMOOTH_EN
  localparam int KNOB_W = 12;
`else
  localparam int KNOB_W = 10;
`endif

  state_e            state_q, state_d;
  logic [9:0]        level_q, level_d;
  logic [9:0]        peak_q, peak_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic              pending_valid_q, pending_valid_d;
  logic [9:0]        pending_peak_q, pending_peak_d;
  logic [KNOB_W-1:0] knob_reg_q, knob_reg_d;
  logic [9:0]        drive_out_q, drive_out_d;
  logic              frame_tick_q, frame_tick_d;

  logic       tick;
  logic       eff_valid;
  logic [9:0] trig_peak;
  logic [9:0] eff_peak;
  state_e     work_state;
  logic [9:0] work_peak;
  logic [10:0] attack_sum;
  logic [9:0]  knob_int;
  logic [10:0] drive_sum;
`ifdef VIDEO_DRIVE_KNOB_SMOOTH_EN
  logic signed [12:0] knob_diff;
  logic signed [12:0] knob_delta;
`endif

  always_comb begin
    tick       = (h_count_in == 11'(H_ACTIVE)) && (v_count_in == 10'(V_ACTIVE));
    trig_peak  = trig ? {trig_velocity, 3'b000} : 10'd0;
    eff_peak   = (trig_peak > pending_peak_q) ? trig_peak : pending_peak_q;
    eff_valid  = pending_valid_q | trig;

    state_d         = state_q;
    level_d         = level_q;
    peak_d          = peak_q;
    hold_cnt_d      = hold_cnt_q;
    pending_valid_d = pending_valid_q;
    pending_peak_d  = pending_peak_q;
    knob_reg_d      = knob_reg_q;
    drive_out_d     = drive_out_q;
    frame_tick_d    = tick;
    work_state      = state_q;
    work_peak       = peak_q;
    attack_sum      = 11'd0;
    knob_int        = 10'd0;
    drive_sum       = 11'd0;
`ifdef VIDEO_DRIVE_KNOB_SMOOTH_EN
    knob_diff       = 13'sd0;
    knob_delta      = 13'sd0;
`endif

    if (!tick) begin
      if (trig) begin
        pending_valid_d = 1'b1;
        pending_peak_d  = eff_peak;
      end
    end else begin
      // A pending or coincident trigger restarts the attack from the current level.
      if (eff_valid) begin
        work_peak  = (eff_peak > level_q) ? eff_peak : level_q;
        work_state = ATTACK;
      end
      peak_d = work_peak;

      case (work_state)
        IDLE: begin
          level_d = 10'd0;
        end
        ATTACK: begin
          attack_sum = {1'b0, level_q} + 11'(ATTACK_STEP);
          level_d    = (attack_sum >= {1'b0, work_peak}) ? work_peak : attack_sum[9:0];
          if (level_d == work_peak) begin
            state_d    = HOLD;
            hold_cnt_d = 8'(HOLD_FRAMES);
          end else begin
            state_d = ATTACK;
          end
        end
        HOLD: begin
          hold_cnt_d = hold_cnt_q - 8'd1;
          if (hold_cnt_d == 8'd0) state_d = DECAY;
        end
        DECAY: begin
          level_d = (level_q > 10'(DECAY_STEP)) ? (level_q - 10'(DECAY_STEP)) : 10'd0;
          if (level_d == 10'd0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      pending_valid_d = 1'b0;
      pending_peak_d  = 10'd0;

`ifdef VIDEO_DRIVE_KNOB_SMOOTH_EN
      // One-pole filter in 10.2 fixed point; arithmetic shift keeps the sign of the step.
      knob_diff  = $signed({1'b0, knob_drive, 2'b00}) - $signed({1'b0, knob_reg_q});
      knob_delta = knob_diff >>> 2;
      knob_reg_d = knob_reg_q + knob_delta[11:0];
      knob_int   = knob_reg_d[11:2];
`else
      knob_reg_d = knob_drive;
      knob_int   = knob_reg_d;
`endif

      drive_sum   = {1'b0, knob_int} + {1'b0, level_d};
      drive_out_d = drive_sum[10] ? 10'd1023 : drive_sum[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      level_q         <= 10'd0;
      peak_q          <= 10'd0;
      hold_cnt_q      <= 8'd0;
      pending_valid_q <= 1'b0;
      pending_peak_q  <= 10'd0;
      knob_reg_q      <= '0;
      drive_out_q     <= 10'd0;
      frame_tick_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      peak_q          <= peak_d;
      hold_cnt_q      <= hold_cnt_d;
      pending_valid_q <= pending_valid_d;
      pending_peak_q  <= pending_peak_d;
      knob_reg_q      <= knob_reg_d;
      drive_out_q     <= drive_out_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign drive_out  = drive_out_q;
  assign env_level  = level_q;
  assign busy       = (state_q != IDLE);
  assign frame_tick = frame_tick_q;

endmodule
